gonsolo_io_ctrl: RTL and testbench
==================================

# gonsolo_io_ctrl

Wishbone-slave configuration and event controller for the 16 user pads (io[7:0] and io[37:30]) in the gonsolo user project. It owns the pad output, output-enable and input paths. Input pads pass through a two-flop synchronizer with per-pin rising/falling edge capture, and edges raise a sticky interrupt on user_irq[0]. The block sits directly between the management SoC Wishbone port and the pad bus.

## Interface
- BASE_ADDR, 32'h3000_0000: Wishbone base; decoded on wbs_adr_i[31:8]
- NPADS, 16: pad count; fixed at 16, where bit i<8 is io[i] and bit i>=8 is io[22+i]
- wb_clk_i  in  1  single clock; all state is on the rising edge
- wb_rst_n_i  in  1  reset, synchronous, active-low
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic control
- wbs_sel_i  in  4  byte lane enables
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  transfer acknowledge
- wbs_dat_o  out  32  read data
- la_data_in  in  128  logic-analyzer data (override build only)
- la_oenb  in  128  logic-analyzer enable, active-low (override build only)
- la_data_out  out  128  logic-analyzer readback
- pad_in  in  16  raw pad inputs
- pad_out  out  16  pad output values
- pad_oeb  out  16  pad output-enable, active-low
- irq  out  3  interrupts; irq[0] is the edge event, irq[2:1] are tied to 0

## Operation
- Register map (word offset wbs_adr_i[4:2]):
  - 0 OUT[15:0]: read/write.
  - 1 OE[15:0]: read/write; 1 = drive the pad.
  - 2 IN[15:0]: read-only; synchronized pad values.
  - 3 EDGE_EN: [15:0] rise enable, [31:16] fall enable.
  - 4 STATUS: [15:0] rise seen, [31:16] fall seen; write-1-to-clear.
  - 5 IRQ_EN[0]: global enable.
  - Offsets 6 and 7 read 0; writes to them are ignored.
- Unused register bits read 0.
- Writes honour wbs_sel_i per byte lane.
- A transfer is selected when cyc & stb & (adr[31:8] == BASE_ADDR[31:8]). Unselected requests are never acked.
- pad_out = OUT; pad_oeb = ~OE.
- Input path: pad_in -> s1 -> s2 (IN) -> prev.
  - rise = s2 & ~prev & EDGE_EN[i]
  - fall = ~s2 & prev & EDGE_EN[16+i]
  - A detected edge sets the matching STATUS bit.
- Edge arming: a 2-bit counter blocks edge detection for the first 3 cycles after reset release, so reset-time pad levels cause no false events.
- irq[0] = IRQ_EN & |STATUS, registered.
- la_data_out[15:0] = IN; la_data_out[127:16] = 0.
- Simultaneous edge set and W1C clear on the same STATUS bit: set wins, and the bit stays 1.

## Timing
- Reset values while wb_rst_n_i = 0, sampled at the clock edge:
  - OUT=0, OE=0, EDGE_EN=0, STATUS=0, IRQ_EN=0.
  - s1, s2 and prev = 0; arm counter = 0.
  - wbs_ack_o=0, wbs_dat_o=0, irq=0, pad_out=0, pad_oeb=16'hFFFF.
- Ack behaviour:
  - wbs_ack_o asserts exactly one cycle after a selected request is first sampled, and stays high for one cycle.
  - It does not re-assert while ack is high, so back-to-back requests see one idle cycle between acks.
- Read data is registered and valid in the ack cycle. wbs_dat_o is 0 when ack is low.
- A write takes effect on the ack edge; pad_out and pad_oeb change in the cycle ack is high.
- A pad change appears in IN 2 cycles later. STATUS sets 3 cycles after the pad change, and irq[0] rises 4 cycles after it.
- Reset asserted mid-transfer: ack drops on the next edge and the partial write is discarded. The master must retry.

## Configuration
- GONSOLO_LA_OVERRIDE_EN defined:
  - For each pad i with la_oenb[i] = 0: pad_out[i] = la_data_in[i] and pad_oeb[i] = ~la_data_in[16+i].
  - These override OUT and OE combinationally; the registers themselves are unchanged.
- Undefined:
  - la_data_in and la_oenb are ignored.
  - Pads are controlled only by the registers.
  - Port list is identical in both builds.

## Test plan
- Reset check: after reset, read all 8 offsets -> every offset reads 0; pad_oeb = FFFF; irq = 0; ack = 0 during reset.
- Register writes: write OE=0x00F0, then write OUT=0x12A5 with sel=4'b0001 -> pad_oeb=FF0F, pad_out=0x00A5; ack pulses 1 cycle after each request.
- Rising edge: EDGE_EN=0x0000_0001, IRQ_EN=1, drive pad_in[0] 0->1 -> STATUS=0x1 after 3 cycles and irq[0]=1 at cycle 4. Write STATUS=0x1 -> irq[0] drops the next cycle.
- Clear/set collision: pad_in[9] falls with EDGE_EN[25]=1 in the same cycle that STATUS is written with 0x0200_0000 -> STATUS[25] stays 1.
- Reset-time levels and selection: hold pad_in=FFFF through reset with all edges enabled -> no STATUS bits set in the 10 cycles after release. A request with adr=0x3000_0100 -> no ack.
- Override build (GONSOLO_LA_OVERRIDE_EN): la_oenb[3]=0, la_data_in[3]=1, la_data_in[19]=1, OE=0 -> pad_out[3]=1 and pad_oeb[3]=0.

Source files
------------

// File: rtl/gonsolo_io_ctrl.sv
// Wishbone-slave pad controller for the 16 gonsolo user pads: output/enable registers,
// synchronized inputs with sticky edge events on irq[0]. Optional macro GONSOLO_LA_OVERRIDE_EN.
module gonsolo_io_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          NPADS     = 16
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    input  logic [127:0]       la_data_in,
    input  logic [127:0]       la_oenb,
    output logic [127:0]       la_data_out,
    input  logic [NPADS-1:0]   pad_in,
    output logic [NPADS-1:0]   pad_out,
    output logic [NPADS-1:0]   pad_oeb,
    output logic [2:0]         irq
);

    logic [15:0] out_q, out_d, oe_q, oe_d;
    logic [31:0] edge_q, edge_d, status_q, status_d;
    logic        irq_en_q, irq_en_d, irq_q, irq_d;
    logic [15:0] s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
    logic [1:0]  arm_q, arm_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;

    logic        req, accept, wr, armed;
    logic [2:0]  off;
    logic [31:0] wmask, rdata, clear, set;
    logic [15:0] rise, fall;

    always_comb begin
        req    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
        // One acked beat per request: a request still held during the ack cycle is not re-accepted.
        accept = req & ~ack_q;
        wr     = accept & wbs_we_i;
        off    = wbs_adr_i[4:2];
        wmask  = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

        rdata = 32'd0;
        case (off)
            3'd0:    rdata = {16'd0, out_q};
            3'd1:    rdata = {16'd0, oe_q};
            3'd2:    rdata = {16'd0, s2_q};
            3'd3:    rdata = edge_q;
            3'd4:    rdata = status_q;
            3'd5:    rdata = {31'd0, irq_en_q};
            default: rdata = 32'd0;
        endcase

        ack_d = accept;
        dat_d = accept ? rdata : 32'd0;

        s1_d   = pad_in;
        s2_d   = s1_q;
        prev_d = s2_q;

        // Edges are ignored until the synchronizer has flushed its reset-time zeros.
        armed = (arm_q == 2'd3);
        arm_d = armed ? arm_q : arm_q + 2'd1;

        rise  = s2_q & ~prev_q & edge_q[15:0];
        fall  = ~s2_q & prev_q & edge_q[31:16];
        set   = armed ? {fall, rise} : 32'd0;
        clear = (wr && off == 3'd4) ? (wbs_dat_i & wmask) : 32'd0;
        status_d = (status_q & ~clear) | set;

        irq_d = irq_en_q & (|status_q);

        out_d    = out_q;
        oe_d     = oe_q;
        edge_d   = edge_q;
        irq_en_d = irq_en_q;
        if (wr) begin
            case (off)
                3'd0:    out_d    = (out_q & ~wmask[15:0]) | (wbs_dat_i[15:0] & wmask[15:0]);
                3'd1:    oe_d     = (oe_q & ~wmask[15:0]) | (wbs_dat_i[15:0] & wmask[15:0]);
                3'd3:    edge_d   = (edge_q & ~wmask) | (wbs_dat_i & wmask);
                3'd5:    irq_en_d = wmask[0] ? wbs_dat_i[0] : irq_en_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            out_q    <= 16'd0;
            oe_q     <= 16'd0;
            edge_q   <= 32'd0;
            status_q <= 32'd0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
            s1_q     <= 16'd0;
            s2_q     <= 16'd0;
            prev_q   <= 16'd0;
            arm_q    <= 2'd0;
            ack_q    <= 1'b0;
            dat_q    <= 32'd0;
        end else begin
            out_q    <= out_d;
            oe_q     <= oe_d;
            edge_q   <= edge_d;
            status_q <= status_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            prev_q   <= prev_d;
            arm_q    <= arm_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign irq         = {2'b00, irq_q};
    assign la_data_out = {112'd0, s2_q};

`ifdef GONSOLO_LA_OVERRIDE_EN
    // Logic-analyzer override is combinational and leaves OUT/OE untouched.
    always_comb begin
        pad_out = out_q;
        pad_oeb = ~oe_q;
        for (int i = 0; i < 16; i++) begin
            if (!la_oenb[i]) begin
                pad_out[i] = la_data_in[i];
                pad_oeb[i] = ~la_data_in[16+i];
            end
        end
    end
`else
    assign pad_out = out_q;
    assign pad_oeb = ~oe_q;
`endif

    logic unused_sig;
    assign unused_sig = ^{la_data_in, la_oenb, wbs_adr_i[7:5], wbs_adr_i[1:0]};

endmodule

// File: tb/tb_gonsolo_io_ctrl.sv
// Scoreboard bench for gonsolo_io_ctrl: directed test-plan sequences followed by random
// register traffic and pad toggling, checked against a cycle-level behavioural model.
module tb_gonsolo_io_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]   sel = 4'd0;
    logic [31:0]  adr = 32'd0, dat = 32'd0;
    logic [127:0] la_data_in = '0, la_oenb = '1;
    logic [15:0]  pad_in = 16'd0;

    logic         ack;
    logic [31:0]  dat_o;
    logic [127:0] la_data_out;
    logic [15:0]  pad_out, pad_oeb;
    logic [2:0]   irq;

    int           vectors = 0;
    int           errors = 0;
    logic [31:0]  last_rd = 32'd0;
    bit           done = 1'b0;

    localparam logic [31:0] BASE = 32'h3000_0000;

    always #5 clk = ~clk;

    gonsolo_io_ctrl dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (dat),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (dat_o),
        .la_data_in  (la_data_in),
        .la_oenb     (la_oenb),
        .la_data_out (la_data_out),
        .pad_in      (pad_in),
        .pad_out     (pad_out),
        .pad_oeb     (pad_oeb),
        .irq         (irq)
    );

    // Reference model state: register file, pad sample history (newest first), handshake.
    logic [15:0] m_out = 16'd0, m_oe = 16'd0;
    logic [31:0] m_edge = 32'd0, m_status = 32'd0;
    logic        m_irqen = 1'b0, m_irq = 1'b0, m_ack = 1'b0;
    int          m_cnt = 0;
    logic [15:0] hist [3];

    logic [32:0] exp_q [$];  // {check_data, read data} per acked transfer
    logic [49:0] cyc_q [$];  // {ack, irq0, IN, pad_oeb, pad_out} per clock edge

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Predicts the effect of the next rising edge from the inputs currently driven.
    task automatic model_step();
        logic [31:0] rd, mask, set, clr;
        logic        acc, new_irq;
        logic [15:0] s2, prev, po, pe;
        if (!rst_n) begin
            m_out = 0; m_oe = 0; m_edge = 0; m_status = 0;
            m_irqen = 0; m_irq = 0; m_ack = 0; m_cnt = 0;
            hist[0] = 0; hist[1] = 0; hist[2] = 0;
        end else begin
            m_cnt++;
            acc  = cyc && stb && (adr[31:8] == BASE[31:8]) && !m_ack;
            s2   = hist[1];
            prev = hist[2];
            case (adr[4:2])
                3'd0:    rd = {16'd0, m_out};
                3'd1:    rd = {16'd0, m_oe};
                3'd2:    rd = {16'd0, s2};
                3'd3:    rd = m_edge;
                3'd4:    rd = m_status;
                3'd5:    rd = {31'd0, m_irqen};
                default: rd = 32'd0;
            endcase
            mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
            set = 32'd0;
            if (m_cnt >= 4) begin
                set[15:0]  = s2 & ~prev & m_edge[15:0];
                set[31:16] = ~s2 & prev & m_edge[31:16];
            end
            clr = (acc && we && adr[4:2] == 3'd4) ? (dat & mask) : 32'd0;
            new_irq = m_irqen && (m_status != 0);
            if (acc) exp_q.push_back({!we, rd});
            if (acc && we) begin
                case (adr[4:2])
                    3'd0: m_out  = (m_out & ~mask[15:0]) | (dat[15:0] & mask[15:0]);
                    3'd1: m_oe   = (m_oe & ~mask[15:0]) | (dat[15:0] & mask[15:0]);
                    3'd3: m_edge = (m_edge & ~mask) | (dat & mask);
                    3'd5: if (sel[0]) m_irqen = dat[0];
                    default: ;
                endcase
            end
            m_status = (m_status & ~clr) | set;
            m_irq = new_irq;
            m_ack = acc;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = pad_in;
        end
        po = m_out;
        pe = ~m_oe;
`ifdef GONSOLO_LA_OVERRIDE_EN
        for (int i = 0; i < 16; i++) begin
            if (!la_oenb[i]) begin
                po[i] = la_data_in[i];
                pe[i] = ~la_data_in[16+i];
            end
        end
`endif
        cyc_q.push_back({m_ack, m_irq, hist[1], pe, po});
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic wb(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d);
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat = d;
        tick();
        tick();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_wr(input logic [2:0] o, input logic [31:0] d, input logic [3:0] s);
        wb(BASE | {27'd0, o, 2'b00}, 1'b1, s, d);
    endtask

    task automatic wb_rd(input logic [2:0] o);
        wb(BASE | {27'd0, o, 2'b00}, 1'b0, 4'hF, 32'd0);
    endtask

    // Monitor: compares every edge's outputs and pops the scoreboard on expected acks.
    initial begin
        logic [49:0] e;
        logic [32:0] x;
        forever begin
            @(posedge clk);
            #1;
            if (done) break;
            if (cyc_q.size() == 0) begin
                chk("cycle_expectation_present", 64'(0), 64'(1));
                continue;
            end
            e = cyc_q.pop_front();
            chk("ack", 64'(ack), 64'(e[49]));
            chk("irq", 64'(irq), 64'({2'b00, e[48]}));
            chk("la_in", 64'(la_data_out[15:0]), 64'(e[47:32]));
            chk("la_upper", 64'(la_data_out[127:16] != 112'd0), 64'(0));
            chk("pad_oeb", 64'(pad_oeb), 64'(e[31:16]));
            chk("pad_out", 64'(pad_out), 64'(e[15:0]));
            if (e[49]) begin
                if (exp_q.size() == 0) begin
                    chk("read_expectation_present", 64'(0), 64'(1));
                end else begin
                    x = exp_q.pop_front();
                    if (x[32]) chk("rdata", 64'(dat_o), 64'(x[31:0]));
                end
                last_rd = dat_o;
            end else begin
                chk("dat_idle", 64'(dat_o), 64'(0));
            end
        end
    end

    initial begin
        logic [15:0] exp_oeb, exp_out;
        hist[0] = 0; hist[1] = 0; hist[2] = 0;
        la_data_in = {$urandom, $urandom, $urandom, $urandom};
`ifdef GONSOLO_LA_OVERRIDE_EN
        la_oenb[3] = 1'b0;
        la_data_in[3] = 1'b1;
        la_data_in[19] = 1'b1;
`endif
        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_ack_low", 64'(ack), 64'(0));
        chk("reset_irq", 64'(irq), 64'(0));
        rst_n = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < 8; i++) begin
            wb_rd(i[2:0]);
            chk("reset_read", 64'(last_rd), 64'(0));
        end

        wb_wr(3'd1, 32'h0000_00F0, 4'hF);
        wb_wr(3'd0, 32'h0000_12A5, 4'h1);
        exp_oeb = 16'hFF0F;
        exp_out = 16'h00A5;
`ifdef GONSOLO_LA_OVERRIDE_EN
        exp_oeb[3] = 1'b0;
        exp_out[3] = 1'b1;
`endif
        chk("oe_write_pad_oeb", 64'(pad_oeb), 64'(exp_oeb));
        chk("sel_write_pad_out", 64'(pad_out), 64'(exp_out));

        wb_wr(3'd4, 32'hFFFF_FFFF, 4'hF);
        wb_wr(3'd3, 32'h0000_0001, 4'hF);
        wb_wr(3'd5, 32'h0000_0001, 4'hF);
        pad_in[0] = 1'b1;
        repeat (3) tick();
        chk("irq_before_4", 64'(irq[0]), 64'(0));
        tick();
        chk("irq_at_4", 64'(irq[0]), 64'(1));
        wb_rd(3'd4);
        chk("status_rise", 64'(last_rd), 64'(1));
        wb_wr(3'd4, 32'h0000_0001, 4'hF);
        chk("irq_after_w1c", 64'(irq[0]), 64'(0));

        wb_wr(3'd3, 32'h0200_0000, 4'hF);
        pad_in[9] = 1'b1;
        repeat (4) tick();
        wb_wr(3'd4, 32'hFFFF_FFFF, 4'hF);
        pad_in[9] = 1'b0;
        tick();
        tick();
        wb_wr(3'd4, 32'h0200_0000, 4'hF);
        wb_rd(3'd4);
        chk("collision_set_wins", 64'(last_rd[25]), 64'(1));

        pad_in = 16'hFFFF;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        wb_wr(3'd3, 32'hFFFF_FFFF, 4'hF);
        repeat (8) tick();
        wb_rd(3'd4);
        chk("reset_levels_no_event", 64'(last_rd), 64'(0));

        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_0100;
        repeat (4) tick();
        chk("unselected_no_ack", 64'(ack), 64'(0));
        cyc = 1'b0; stb = 1'b0;
        tick();

`ifdef GONSOLO_LA_OVERRIDE_EN
        wb_wr(3'd1, 32'h0000_0000, 4'hF);
        chk("override_pad_out3", 64'(pad_out[3]), 64'(1));
        chk("override_pad_oeb3", 64'(pad_oeb[3]), 64'(0));
`endif

        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 5) == 0) pad_in = pad_in ^ 16'($urandom);
            case ($urandom_range(0, 9))
                0, 1: wb_rd(3'($urandom_range(0, 7)));
                2, 3: wb_wr(3'($urandom_range(0, 7)), $urandom, 4'($urandom));
                4: wb({8'h31, 24'($urandom)}, 1'($urandom), 4'hF, $urandom);
                5: begin
                    if ($urandom_range(0, 7) == 0) begin
                        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
                        adr = BASE; dat = $urandom;
                        rst_n = 1'b0;
                        tick();
                        cyc = 1'b0; stb = 1'b0; we = 1'b0;
                        tick();
                        rst_n = 1'b1;
                    end else begin
                        wb_wr(3'd4, $urandom, 4'($urandom));
                    end
                end
                default: tick();
            endcase
        end
        repeat (3) tick();

        done = 1'b1;
        @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
